// File: rtl/mask_pkg.sv
// mask_pkg: shared mask types, scheduler states and index widths
package mask_pkg;
  localparam int ROW_W = 11;
  localparam int SF_W = 10;
  typedef enum logic [1:0] {MT_REPEAT = 2'b00, MT_SLIDE = 2'b01, MT_RANDOM = 2'b10} mask_type_e;
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_GEN, ST_SETTLE, ST_PRESENT, ST_DONE} msched_state_e;
endpackage

// File: rtl/msched_counters.sv
// msched_counters: row/subframe index counters with last-row/last-subframe flags
module msched_counters
  import mask_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  input  logic             advance,
  input  logic [ROW_W-1:0] h_lat,
  input  logic [SF_W-1:0]  nsf_lat,
  output logic [ROW_W-1:0] row_idx,
  output logic [SF_W-1:0]  subframe_idx,
  output logic             last_row,
  output logic             last_sf
);
  assign last_row = row_idx == h_lat - 1'b1;
  assign last_sf = subframe_idx == nsf_lat - 1'b1;
  // the final transfer of a frame leaves both indices parked; only clear rewinds them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_idx <= '0;
      subframe_idx <= '0;
    end else if (en) begin
      if (clear) begin
        row_idx <= '0;
        subframe_idx <= '0;
      end else if (advance && !last_row) begin
        row_idx <= row_idx + 1'b1;
      end else if (advance && !last_sf) begin
        row_idx <= '0;
        subframe_idx <= subframe_idx + 1'b1;
      end
    end
  end
endmodule

// File: rtl/mask_row_scheduler.sv
// mask_row_scheduler: sequences the mask generator over one frame and hands captured rows to the driver.
// Define MASK_SEQ_RELOAD_EN to reload the pattern at every subframe boundary.
module mask_row_scheduler
  import mask_pkg::*;
#(
  parameter int max_image_sensor_w = 1920,
  parameter int max_image_sensor_h = 1080,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clk_en,
  input  logic                          start,
  input  logic                          abort,
  input  logic [SF_W-1:0]               num_subframes,
  input  logic [ROW_W-1:0]              image_sensor_h,
  input  logic [1:0]                    mask_type_cfg,
  input  logic                          gen_valid,
  input  logic [max_image_sensor_w-1:0] gen_mask,
  output logic                          gen_load,
  output logic                          gen_en,
  output logic [1:0]                    gen_mask_type,
  output logic [max_image_sensor_w-1:0] row_mask,
  output logic                          row_valid,
  input  logic                          row_ready,
  output logic [ROW_W-1:0]              row_idx,
  output logic [SF_W-1:0]               subframe_idx,
  output logic                          busy,
  output logic                          frame_done
);
`ifdef MASK_SEQ_RELOAD_EN
  localparam msched_state_e SF_NEXT = ST_LOAD;
`else
  localparam msched_state_e SF_NEXT = ST_GEN;
`endif
  localparam logic [ROW_W-1:0] H_MAX = ROW_W'(max_image_sensor_h);
  msched_state_e state, next;
  logic first_gen;
  logic [1:0] settle_cnt;
  logic [SF_W-1:0] nsf_lat;
  logic [ROW_W-1:0] h_lat;
  mask_type_e mt_lat;
  logic last_row, last_sf, settle_done, start_ok, advance;
  assign settle_done = state == ST_SETTLE && settle_cnt == 2'(SETTLE_CYCLES - 1);
  assign start_ok = state == ST_IDLE && start && !abort;
  assign advance = state == ST_PRESENT && row_ready && !abort;
  assign gen_mask_type = mt_lat;
  always_comb begin
    next = state;
    case (state)
      ST_IDLE:    next = !start ? ST_IDLE : (num_subframes == '0 || image_sensor_h == '0) ? ST_DONE : ST_LOAD;
      ST_LOAD:    next = ST_GEN;
      ST_GEN:     next = (gen_valid && !first_gen) ? ST_SETTLE : ST_GEN;
      ST_SETTLE:  next = settle_done ? ST_PRESENT : ST_SETTLE;
      ST_PRESENT: next = !row_ready ? ST_PRESENT : !last_row ? ST_GEN : !last_sf ? SF_NEXT : ST_DONE;
      default:    next = ST_IDLE;
    endcase
    if (abort) next = ST_IDLE;
    gen_load = state == ST_LOAD;
    gen_en = clk_en && (state == ST_LOAD || state == ST_GEN);
    row_valid = state == ST_PRESENT;
    busy = state != ST_IDLE;
    frame_done = state == ST_DONE;
  end
  // first_gen masks the stale gen_valid seen on the first cycle after (re)entering GEN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      first_gen <= 1'b0;
      settle_cnt <= 2'd0;
      nsf_lat <= '0;
      h_lat <= '0;
      mt_lat <= MT_REPEAT;
      row_mask <= '0;
    end else if (clk_en) begin
      state <= next;
      first_gen <= next == ST_GEN && state != ST_GEN;
      settle_cnt <= state == ST_SETTLE ? settle_cnt + 2'd1 : 2'd0;
      if (start_ok) begin
        nsf_lat <= num_subframes;
        h_lat <= image_sensor_h > H_MAX ? H_MAX : image_sensor_h;
        mt_lat <= mask_type_e'(mask_type_cfg);
      end
      if (settle_done && !abort) row_mask <= gen_mask;
    end
  end
  msched_counters u_cnt (
    .clk(clk),
    .rst_n(rst_n),
    .en(clk_en),
    .clear(start_ok),
    .advance(advance),
    .h_lat(h_lat),
    .nsf_lat(nsf_lat),
    .row_idx(row_idx),
    .subframe_idx(subframe_idx),
    .last_row(last_row),
    .last_sf(last_sf)
  );
endmodule

// File: tb/tb_mask_row_scheduler.sv
// tb_mask_row_scheduler: scoreboard bench with a generator model and directed frame scenarios
module tb_mask_row_scheduler;
  localparam int W = 64;
  logic clk = 0, rst_n, clk_en, start, abort, gen_valid, row_ready;
  logic [9:0] nsf;
  logic [10:0] h;
  logic [1:0] mt;
  logic [W-1:0] gen_mask, row_mask;
  logic gen_load, gen_en, row_valid, busy, frame_done;
  logic [1:0] gen_mask_type;
  logic [10:0] row_idx;
  logic [9:0] subframe_idx;
  typedef struct {logic [9:0] sf; logic [10:0] r; logic [W-1:0] m;} exp_t;
  exp_t q[$];
  exp_t me;
  int n_cmp = 0, n_err = 0, n_load = 0, n_done = 0, n_rv = 0, total = 0, gcnt = 0;
  logic tog = 0;
`ifdef MASK_SEQ_RELOAD_EN
  localparam int EXP_LOADS = 2;
`else
  localparam int EXP_LOADS = 1;
`endif

  mask_row_scheduler #(.max_image_sensor_w(W), .max_image_sensor_h(1080), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .start(start), .abort(abort),
    .num_subframes(nsf), .image_sensor_h(h), .mask_type_cfg(mt),
    .gen_valid(gen_valid), .gen_mask(gen_mask), .gen_load(gen_load), .gen_en(gen_en),
    .gen_mask_type(gen_mask_type), .row_mask(row_mask), .row_valid(row_valid),
    .row_ready(row_ready), .row_idx(row_idx), .subframe_idx(subframe_idx),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] pat(input int k);
    logic [31:0] kk = 32'(k);
    return {kk * 32'h01000193 ^ 32'hA5A5A5A5, 32'hDEAD0000 | kk};
  endfunction

  // generator model: valid once 5 enabled cycles have elapsed since the last row was presented
  always @(posedge clk or negedge rst_n)
    if (!rst_n) gcnt <= 0;
    else if (row_valid || !busy) gcnt <= 0;
    else if (gen_en) gcnt <= gcnt + 1;
  assign gen_valid = gcnt >= 5;
  assign gen_mask = pat(total);

  task automatic chk(input string nm, input logic [W-1:0] a, input logic [W-1:0] b);
    n_cmp++;
    if (a !== b) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, a, b);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    if (gen_load && clk_en) n_load++;
    if (frame_done && clk_en) n_done++;
    if (row_valid) n_rv++;
    if (!clk_en) chk("gen_en_gated", W'(gen_en), 0);
    if (row_valid && row_ready && clk_en) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_row: got sf %0d row %0d, required no transfer", subframe_idx, row_idx);
      end else begin
        me = q.pop_front();
        chk("row_idx", W'(row_idx), W'(me.r));
        chk("subframe_idx", W'(subframe_idx), W'(me.sf));
        chk("row_mask", row_mask, me.m);
      end
      total++;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (tog) clk_en = ~clk_en;
  end

  task automatic push_frame(input int ns, input int hh);
    int k = 0;
    for (int s = 0; s < ns; s++)
      for (int r = 0; r < hh; r++) begin
        q.push_back('{10'(s), 11'(r), pat(total + k)});
        k++;
      end
  endtask

  task automatic pulse_start(input int ns, input int hh, input int m);
    nsf = 10'(ns);
    h = 11'(hh);
    mt = 2'(m);
    @(posedge clk) #1 start = 1;
    @(posedge clk) #1 start = 0;
  endtask

  task automatic wait_frame(input int d0, input string nm);
    int c = 0;
    while (n_done == d0 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk(nm, W'(n_done != d0), 1);
    chk({nm, "_queue_empty"}, W'(q.size()), 0);
  endtask

  task automatic wait_rv(input string nm);
    int c = 0;
    while (!row_valid && c < 500) begin
      @(negedge clk);
      c++;
    end
    chk(nm, W'(row_valid), 1);
  endtask

  initial begin
    int d0, l0, r0;
    rst_n = 0; clk_en = 1; start = 0; abort = 0; row_ready = 0; nsf = 0; h = 0; mt = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", W'(busy), 0);
    chk("rst_row_valid", W'(row_valid), 0);
    chk("rst_gen_load", W'(gen_load), 0);
    chk("rst_gen_en", W'(gen_en), 0);
    chk("rst_frame_done", W'(frame_done), 0);
    chk("rst_row_mask", row_mask, 0);
    chk("rst_idx", W'({subframe_idx, row_idx}), 0);
    chk("rst_mask_type", W'(gen_mask_type), 0);
    rst_n = 1;

    // basic frame: 2 subframes x 3 rows, always ready
    row_ready = 1;
    d0 = n_done; l0 = n_load;
    push_frame(2, 3);
    pulse_start(2, 3, 1);
    @(negedge clk);
    chk("s1_load_after_start", W'(gen_load), 1);
    chk("s1_busy", W'(busy), 1);
    @(negedge clk);
    chk("s1_load_one_cycle", W'(gen_load), 0);
    nsf = 0; h = 1; mt = 2;
    wait_frame(d0, "s1_frame_done");
    chk("s1_gen_load_count", W'(n_load - l0), EXP_LOADS);
    chk("s1_mask_type_latched", W'(gen_mask_type), 1);
    repeat (3) @(negedge clk);
    chk("s1_single_done", W'(n_done - d0), 1);
    chk("s1_idle", W'(busy), 0);

    // backpressure: hold the first row for 10 cycles
    row_ready = 0;
    d0 = n_done;
    push_frame(1, 2);
    pulse_start(1, 2, 0);
    wait_rv("bp_row_valid");
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid_held", W'(row_valid), 1);
      chk("bp_mask_held", row_mask, pat(total));
      chk("bp_idx_held", W'(row_idx), 0);
      chk("bp_gen_en_low", W'(gen_en), 0);
    end
    @(posedge clk) #1 row_ready = 1;
    wait_frame(d0, "bp_frame_done");

    // empty frame
    d0 = n_done; l0 = n_load; r0 = n_rv;
    pulse_start(0, 3, 0);
    @(negedge clk);
    chk("zero_nsf_done", W'(frame_done), 1);
    @(negedge clk);
    chk("zero_nsf_done_pulse", W'(frame_done), 0);
    chk("zero_nsf_idle", W'(busy), 0);
    chk("zero_nsf_no_load", W'(n_load - l0), 0);
    chk("zero_nsf_no_row", W'(n_rv - r0), 0);
    chk("zero_nsf_done_count", W'(n_done - d0), 1);

    // abort while row 1 is presented
    row_ready = 0;
    d0 = n_done;
    push_frame(2, 3);
    pulse_start(2, 3, 0);
    wait_rv("ab_row0_valid");
    @(posedge clk) #1 row_ready = 1;
    @(posedge clk) #1 row_ready = 0;
    wait_rv("ab_row1_valid");
    chk("ab_row1_idx", W'(row_idx), 1);
    @(posedge clk) #1 abort = 1;
    @(posedge clk) #1 abort = 0;
    @(negedge clk);
    chk("ab_row_valid_drop", W'(row_valid), 0);
    chk("ab_idle", W'(busy), 0);
    repeat (5) @(negedge clk);
    chk("ab_no_done", W'(n_done - d0), 0);
    q.delete();
    row_ready = 1;
    push_frame(1, 1);
    pulse_start(1, 1, 0);
    wait_frame(d0, "ab_restart_done");

    // clk_en toggling with a start while busy
    d0 = n_done; l0 = n_load;
    push_frame(2, 3);
    pulse_start(2, 3, 1);
    tog = 1;
    repeat (20) @(posedge clk);
    nsf = 1; h = 1; mt = 2;
    #1 start = 1;
    repeat (3) @(posedge clk);
    #1 start = 0;
    wait_frame(d0, "ce_frame_done");
    @(posedge clk) #1 tog = 0;
    clk_en = 1;
    repeat (8) @(negedge clk);
    chk("ce_single_done", W'(n_done - d0), 1);
    chk("ce_gen_load_count", W'(n_load - l0), EXP_LOADS);
    chk("ce_mask_type", W'(gen_mask_type), 1);

    // asynchronous reset during GEN
    pulse_start(1, 3, 2);
    begin
      int c = 0;
      while (!(gen_en && !gen_load) && c < 100) begin
        @(negedge clk);
        c++;
      end
    end
    chk("ar_in_gen", W'(gen_en && busy), 1);
    #2 rst_n = 0;
    #1;
    chk("ar_busy", W'(busy), 0);
    chk("ar_gen_en", W'(gen_en), 0);
    chk("ar_gen_load", W'(gen_load), 0);
    chk("ar_mask_type", W'(gen_mask_type), 0);
    chk("ar_row_valid", W'(row_valid), 0);
    chk("ar_idx", W'({subframe_idx, row_idx}), 0);
    chk("ar_row_mask", row_mask, 0);
    @(negedge clk) rst_n = 1;
    q.delete();
    repeat (2) @(negedge clk);
    chk("ar_idle_after_release", W'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end
endmodule
